// File: rtl/branch_target_unit_if.sv
// Request/result handshake bundle for the branch target unit.
// The producer side (decode/nPC logic) uses master, the unit itself uses slave.
interface branch_target_unit_if #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
);
    logic              in_flush;
    logic              in_valid;
    logic              in_ready;
    logic [ADDR_W-1:0] in_pc;
    logic [29:0]       in_disp;
    logic [1:0]        in_mode;
    logic              out_valid;
    logic              out_ready;
    logic [ADDR_W-1:0] out_target;
    logic              out_wrap;
    logic              out_misalign;
    logic [CNT_W-1:0]  out_count;

    modport master (
        output in_flush, in_valid, in_pc, in_disp, in_mode, out_ready,
        input  in_ready, out_valid, out_target, out_wrap, out_misalign, out_count
    );

    modport slave (
        input  in_flush, in_valid, in_pc, in_disp, in_mode, out_ready,
        output in_ready, out_valid, out_target, out_wrap, out_misalign, out_count
    );
endinterface

// File: rtl/branch_target_unit.sv
// Two-stage elastic SPARC branch/call target generator: PC + (sign-extended
// displacement << 2), with wrap/misalign flags and a saturating transfer counter.
module branch_target_unit #(
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input logic                 clk,
    input logic                 reset,
    branch_target_unit_if.slave bus
);
    localparam int EXT_W = ADDR_W - 2;

    function automatic logic signed [ADDR_W-1:0] make_offset(input logic [29:0] disp,
                                                              input logic [1:0]  mode);
        logic signed [EXT_W-1:0] ext;
        case (mode)
            2'b00:   ext = EXT_W'(signed'(disp[21:0]));
            2'b01:   ext = EXT_W'(signed'(disp[29:0]));
            2'b10:   ext = EXT_W'(signed'(disp[18:0]));
            default: ext = EXT_W'(signed'({disp[21:20], disp[13:0]}));
        endcase
        return {ext, 2'b00};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        return (&cnt) ? cnt : cnt + 1'b1;
    endfunction

    // A negative offset always produces a carry unless it crosses below zero,
    // so the exact result escapes the address space when carry and sign disagree.
    function automatic logic wrap_flag(input logic carry, input logic sign);
        return carry ^ sign;
    endfunction

    logic                     vld_p1;
    logic [ADDR_W-1:0]        pc_p1;
    logic signed [ADDR_W-1:0] off_p1;
    logic                     mis_p1;
    logic                     vld_p2;
    logic [ADDR_W-1:0]        target_p2;
    logic                     wrap_p2;
    logic                     mis_p2;
    logic [CNT_W-1:0]         xfer_cnt;

    logic              s2_load;
    logic              s1_load;
    logic              in_take;
    logic              out_take;
    logic [ADDR_W:0]   sum_p1;

    assign s2_load      = !vld_p2 || bus.out_ready;
    assign s1_load      = !vld_p1 || s2_load;
    assign bus.in_ready = !bus.in_flush && s1_load;
    assign in_take      = bus.in_valid && bus.in_ready;
    assign out_take     = vld_p2 && bus.out_ready;
    assign sum_p1       = {1'b0, pc_p1} + {1'b0, off_p1};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1   <= 1'b0;
            vld_p2   <= 1'b0;
            xfer_cnt <= '0;
        end else begin
            if (out_take)
                xfer_cnt <= sat_inc(xfer_cnt);
            if (bus.in_flush) begin
                vld_p1 <= 1'b0;
                vld_p2 <= 1'b0;
            end else begin
                if (s2_load)
                    vld_p2 <= vld_p1;
                if (s1_load)
                    vld_p1 <= in_take;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_p1     <= '0;
            off_p1    <= '0;
            mis_p1    <= 1'b0;
            target_p2 <= '0;
            wrap_p2   <= 1'b0;
            mis_p2    <= 1'b0;
        end else begin
            // Stage 1: capture PC, decoded offset and alignment
            if (in_take) begin
                pc_p1  <= bus.in_pc;
                off_p1 <= make_offset(bus.in_disp, bus.in_mode);
                mis_p1 <= |bus.in_pc[1:0];
            end
            // Stage 2: add and flag; holds while the consumer stalls
            if (s2_load && vld_p1 && !bus.in_flush) begin
                target_p2 <= sum_p1[ADDR_W-1:0];
                wrap_p2   <= wrap_flag(sum_p1[ADDR_W], off_p1[ADDR_W-1]);
                mis_p2    <= mis_p1;
            end
        end
    end

    assign bus.out_valid    = vld_p2;
    assign bus.out_target   = target_p2;
    assign bus.out_wrap     = wrap_p2;
    assign bus.out_misalign = mis_p2;
    assign bus.out_count    = xfer_cnt;
endmodule

// File: tb/tb_branch_target_unit.sv
// Bench for branch_target_unit: directed vector table, handshake corner cases
// and random traffic checked against an arithmetic FIFO model.
module tb_branch_target_unit;
    localparam int ADDR_W = 32;
    localparam int CNT_W  = 4;
    localparam int CMAX   = (1 << CNT_W) - 1;

    typedef struct {
        logic [1:0]  mode;
        logic [31:0] pc;
        logic [29:0] disp;
        logic [31:0] target;
        logic        wrap;
        logic        mis;
    } vec_t;

    typedef struct {
        logic [31:0] target;
        logic        wrap;
        logic        mis;
        int          age;
    } item_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    branch_target_unit_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();
    branch_target_unit #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_b(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Exact target in plain integer arithmetic, wrap judged on the exact value.
    function automatic item_t model_calc(input logic [31:0] pc, input logic [29:0] disp,
                                         input logic [1:0] mode);
        item_t  r;
        longint f;
        longint exact;
        int     w;
        case (mode)
            2'b00:   begin f = longint'(disp[21:0]); w = 22; end
            2'b01:   begin f = longint'(disp[29:0]); w = 30; end
            2'b10:   begin f = longint'(disp[18:0]); w = 19; end
            default: begin f = longint'({disp[21:20], disp[13:0]}); w = 16; end
        endcase
        if (f >= (longint'(1) << (w - 1)))
            f = f - (longint'(1) << w);
        exact    = longint'({32'b0, pc}) + f * 4;
        r.wrap   = (exact < 0) || (exact > longint'({32'b0, 32'hFFFF_FFFF}));
        r.target = exact[31:0];
        r.mis    = (pc[1:0] != 2'b00);
        r.age    = 0;
        return r;
    endfunction

    // Scoreboard: in-order queue of accepted requests, capacity two
    item_t q[$];
    int    mcount;
    logic  mon_ready;
    logic  mon_valid;
    item_t mon_item;

    always @(negedge clk) begin
        if (reset) begin
            q.delete();
            mcount = 0;
        end else begin
            mon_ready = !bus.in_flush && ((q.size() < 2) || bus.out_ready);
            mon_valid = (q.size() > 0) && (q[0].age >= 1);
            check_b("mon_in_ready", bus.in_ready, mon_ready);
            check_b("mon_out_valid", bus.out_valid, mon_valid);
            check("mon_out_count", 32'(bus.out_count), 32'(mcount));
            if (mon_valid && bus.out_valid) begin
                check("mon_target", bus.out_target, q[0].target);
                check_b("mon_wrap", bus.out_wrap, q[0].wrap);
                check_b("mon_misalign", bus.out_misalign, q[0].mis);
            end
            if (mon_valid && bus.out_ready) begin
                void'(q.pop_front());
                if (mcount < CMAX) mcount++;
            end
            for (int i = 0; i < q.size(); i++) q[i].age++;
            if (bus.in_flush) begin
                q.delete();
            end else if (bus.in_valid && mon_ready) begin
                mon_item = model_calc(bus.in_pc, bus.in_disp, bus.in_mode);
                q.push_back(mon_item);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [29:0] disp, input logic [1:0] mode);
        bus.in_valid = 1'b1;
        bus.in_pc    = pc;
        bus.in_disp  = disp;
        bus.in_mode  = mode;
    endtask

    vec_t        vecs[8];
    vec_t        bp[4];
    logic [31:0] obs[$];
    item_t       ref_it;

    initial begin
        int  idx;
        int  stall;
        logic started;
        logic returned;
        logic acc;

        vecs[0] = '{2'b00, 32'h0000_1000, 30'h003F_FFFF, 32'h0000_0FFC, 1'b0, 1'b0};
        vecs[1] = '{2'b01, 32'h0000_0010, 30'h2000_0000, 32'h8000_0010, 1'b1, 1'b0};
        vecs[2] = '{2'b10, 32'hFFFF_FFF0, 30'h0000_0004, 32'h0000_0000, 1'b1, 1'b0};
        vecs[3] = '{2'b11, 32'h0000_0102, 30'h001F_C000, 32'h0001_0102, 1'b0, 1'b1};
        vecs[4] = '{2'b11, 32'h0000_0102, 30'h0010_0000, 32'h0001_0102, 1'b0, 1'b1};
        vecs[5] = '{2'b00, 32'h0000_2000, 30'h3FC0_0001, 32'h0000_2004, 1'b0, 1'b0};
        vecs[6] = '{2'b10, 32'h0000_0003, 30'h0004_0000, 32'hFFF0_0003, 1'b1, 1'b1};
        vecs[7] = '{2'b11, 32'h8000_0000, 30'h0020_0000, 32'h7FFE_0000, 1'b0, 1'b0};
        bp[0] = '{2'b00, 32'h0000_4000, 30'h0000_0010, 32'h0, 1'b0, 1'b0};
        bp[1] = '{2'b01, 32'h0000_4004, 30'h3FFF_FFF0, 32'h0, 1'b0, 1'b0};
        bp[2] = '{2'b10, 32'h0000_4008, 30'h0007_FFFF, 32'h0, 1'b0, 1'b0};
        bp[3] = '{2'b11, 32'h0000_400C, 30'h0000_0100, 32'h0, 1'b0, 1'b0};

        reset         = 1'b1;
        bus.in_flush  = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_pc     = '0;
        bus.in_disp   = '0;
        bus.in_mode   = '0;
        bus.out_ready = 1'b1;

        #12;
        check_b("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_target", bus.out_target, 32'h0);
        check_b("rst_out_wrap", bus.out_wrap, 1'b0);
        check_b("rst_out_misalign", bus.out_misalign, 1'b0);
        check("rst_out_count", 32'(bus.out_count), 32'h0);
        #10 reset = 1'b0;
        tick();
        check_b("rst_in_ready", bus.in_ready, 1'b1);

        // Directed vectors, one at a time, consumer always ready
        foreach (vecs[i]) begin
            drive(vecs[i].pc, vecs[i].disp, vecs[i].mode);
            tick();
            bus.in_valid = 1'b0;
            check_b("vec_latency_s1", bus.out_valid, 1'b0);
            tick();
            check_b("vec_out_valid", bus.out_valid, 1'b1);
            check("vec_target", bus.out_target, vecs[i].target);
            check_b("vec_wrap", bus.out_wrap, vecs[i].wrap);
            check_b("vec_misalign", bus.out_misalign, vecs[i].mis);
        end
        tick();

        // Reset pulsed between edges while a result is presented
        drive(32'h0000_0100, 30'h0000_0001, 2'b00);
        tick();
        drive(32'h0000_0200, 30'h0000_0002, 2'b00);
        tick();
        bus.in_valid = 1'b0;
        check_b("mid_rst_pre_valid", bus.out_valid, 1'b1);
        #2 reset = 1'b1;
        #1;
        check_b("mid_rst_out_valid", bus.out_valid, 1'b0);
        check("mid_rst_out_count", 32'(bus.out_count), 32'h0);
        check("mid_rst_out_target", bus.out_target, 32'h0);
        #3 reset = 1'b0;
        tick();
        check_b("mid_rst_in_ready", bus.in_ready, 1'b1);

        // Backpressure: four back-to-back requests, three stall cycles
        idx = 0; stall = 3; started = 1'b0; returned = 1'b0;
        obs.delete();
        for (int c = 0; c < 20; c++) begin
            if (idx < 4) drive(bp[idx].pc, bp[idx].disp, bp[idx].mode);
            else bus.in_valid = 1'b0;
            if (bus.out_valid && !started) started = 1'b1;
            bus.out_ready = !(started && stall > 0);
            #1;
            if (started && stall > 0) begin
                check_b("bp_in_ready_stall", bus.in_ready, 1'b0);
                check("bp_accepted", 32'(idx), 32'd2);
            end else if (started && !returned) begin
                check_b("bp_ready_return", bus.in_ready, 1'b1);
                returned = 1'b1;
            end
            acc = bus.in_valid && bus.in_ready;
            if (bus.out_valid && bus.out_ready) obs.push_back(bus.out_target);
            tick();
            if (acc) idx++;
            if (started && stall > 0) stall--;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        check("bp_results", 32'(obs.size()), 32'd4);
        for (int i = 0; i < 4; i++) begin
            ref_it = model_calc(bp[i].pc, bp[i].disp, bp[i].mode);
            check("bp_order", (i < obs.size()) ? obs[i] : 32'hDEAD_BEEF, ref_it.target);
        end
        check("bp_out_count", 32'(bus.out_count), 32'd4);

        // Flush with both stages full and consumer stalled
        bus.out_ready = 1'b0;
        drive(32'h0000_0500, 30'h0000_0003, 2'b01);
        tick();
        drive(32'h0000_0600, 30'h0000_0004, 2'b01);
        tick();
        bus.in_valid = 1'b0;
        check_b("fl_full_valid", bus.out_valid, 1'b1);
        bus.in_flush = 1'b1;
        #1;
        check_b("fl_in_ready", bus.in_ready, 1'b0);
        tick();
        bus.in_flush = 1'b0;
        check_b("fl_out_valid", bus.out_valid, 1'b0);
        check("fl_out_count", 32'(bus.out_count), 32'd4);
        #1;
        check_b("fl_in_ready_after", bus.in_ready, 1'b1);

        // Flush coinciding with a completed transfer
        drive(32'h0000_0700, 30'h0000_0005, 2'b10);
        tick();
        drive(32'h0000_0800, 30'h0000_0006, 2'b10);
        tick();
        bus.in_valid  = 1'b0;
        bus.in_flush  = 1'b1;
        bus.out_ready = 1'b1;
        tick();
        bus.in_flush = 1'b0;
        check_b("flx_out_valid", bus.out_valid, 1'b0);
        check("flx_out_count", 32'(bus.out_count), 32'd5);

        // Drive the counter into saturation
        for (int c = 0; c < 20; c++) begin
            drive(32'(c * 4), 30'(c), 2'(c));
            tick();
        end
        bus.in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("sat_out_count", 32'(bus.out_count), 32'(CMAX));

        // Random traffic against the scoreboard
        for (int c = 0; c < 600; c++) begin
            bus.in_valid  = ($urandom_range(0, 3) != 0);
            bus.in_pc     = $urandom;
            bus.in_disp   = 30'($urandom);
            bus.in_mode   = 2'($urandom_range(0, 3));
            bus.out_ready = ($urandom_range(0, 3) != 0);
            bus.in_flush  = ($urandom_range(0, 24) == 0);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.in_flush  = 1'b0;
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        check_b("drain_out_valid", bus.out_valid, 1'b0);
        check("end_out_count", 32'(bus.out_count), 32'(CMAX));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
